// File: rtl/deser_arbiter.sv
// Round-robin arbiter that time-shares one serial deserializer among N_REQ
// requester lanes, tags each captured word with its channel and recovers the
// deserializer after an abort or a missing word-valid.
module deser_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned WORD_W  = 16,
    parameter int unsigned TIMEOUT = 4
) (
    input  logic                     clk_i,
    input  logic                     arst_n_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ-1:0]         data_i,
    input  logic [N_REQ-1:0]         data_val_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic                     deser_srst_o,
    output logic                     deser_data_o,
    output logic                     deser_data_val_o,
    input  logic [WORD_W-1:0]        deser_data_i,
    input  logic                     deser_data_val_i,
    output logic [WORD_W-1:0]        word_o,
    output logic [$clog2(N_REQ)-1:0] word_ch_o,
    output logic                     word_val_o,
    output logic                     abort_o,
    output logic                     timeout_o
);

    localparam int unsigned CH_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(WORD_W + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM  = 2'd1,
        WAIT    = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [N_REQ-1:0]  gnt_d;
    logic              srst_d;
    logic [WORD_W-1:0] word_d;
    logic [CH_W-1:0]   word_ch_d;
    logic              word_val_d;
    logic              abort_d;
    logic              timeout_d;

    logic              pick_vld;
    logic [CH_W-1:0]   pick;
    int unsigned       idx;

    // Round-robin search: first requesting channel after the last winner, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        idx      = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(rr_q) + k) % N_REQ;
            if (!pick_vld && req_i[CH_W'(idx)]) begin
                pick_vld = 1'b1;
                pick     = CH_W'(idx);
            end
        end
    end

    // Zero-latency serial mux into the deserializer, only while streaming.
    always_comb begin
        deser_data_o     = 1'b0;
        deser_data_val_o = 1'b0;
        if (state_q == STREAM) begin
            deser_data_o     = data_i[ch_q];
            deser_data_val_o = data_val_i[ch_q];
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        ch_d       = ch_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        gnt_d      = gnt_o;
        srst_d     = 1'b0;
        word_d     = word_o;
        word_ch_d  = word_ch_o;
        word_val_d = 1'b0;
        abort_d    = 1'b0;
        timeout_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    ch_d        = pick;
                    rr_d        = pick;
                    cnt_d       = '0;
                    state_d     = STREAM;
                end
            end
            STREAM: begin
                // Last valid bit wins over a simultaneous request drop.
                if (data_val_i[ch_q] && (cnt_q == CNT_W'(WORD_W - 1))) begin
                    cnt_d   = '0;
                    tmo_d   = '0;
                    gnt_d   = '0;
                    state_d = WAIT;
                end else if (!req_i[ch_q]) begin
                    cnt_d   = '0;
                    gnt_d   = '0;
                    abort_d = 1'b1;
                    srst_d  = 1'b1;
                    state_d = RECOVER;
                end else if (data_val_i[ch_q]) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                if (deser_data_val_i) begin
                    word_d     = deser_data_i;
                    word_ch_d  = ch_q;
                    word_val_d = 1'b1;
                    state_d    = IDLE;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    srst_d    = 1'b1;
                    state_d   = RECOVER;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            RECOVER: begin
                cnt_d   = '0;
                tmo_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; deserializer held in reset for the first cycle.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q      <= IDLE;
            rr_q         <= CH_W'(N_REQ - 1);
            ch_q         <= '0;
            cnt_q        <= '0;
            tmo_q        <= '0;
            gnt_o        <= '0;
            deser_srst_o <= 1'b1;
            word_o       <= '0;
            word_ch_o    <= '0;
            word_val_o   <= 1'b0;
            abort_o      <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            ch_q         <= ch_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            gnt_o        <= gnt_d;
            deser_srst_o <= srst_d;
            word_o       <= word_d;
            word_ch_o    <= word_ch_d;
            word_val_o   <= word_val_d;
            abort_o      <= abort_d;
            timeout_o    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_deser_arbiter.sv
// Bench for deser_arbiter: acts as the requesters and as a simple
// deserializer, checking grants, forwarding, capture, abort and timeout.
module tb_deser_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 16;
    localparam int unsigned TMO = 4;

    logic          clk_i = 1'b0;
    logic          arst_n_i;
    logic [N-1:0]  req_i, data_i, data_val_i;
    logic [N-1:0]  gnt_o;
    logic          deser_srst_o, deser_data_o, deser_data_val_o;
    logic [W-1:0]  deser_data_i;
    logic          deser_data_val_i;
    logic [W-1:0]  word_o;
    logic [1:0]    word_ch_o;
    logic          word_val_o, abort_o, timeout_o;

    deser_arbiter #(.N_REQ(N), .WORD_W(W), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .req_i(req_i), .data_i(data_i),
        .data_val_i(data_val_i), .gnt_o(gnt_o), .deser_srst_o(deser_srst_o),
        .deser_data_o(deser_data_o), .deser_data_val_o(deser_data_val_o),
        .deser_data_i(deser_data_i), .deser_data_val_i(deser_data_val_i),
        .word_o(word_o), .word_ch_o(word_ch_o), .word_val_o(word_val_o),
        .abort_o(abort_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;
    int model_rr;
    logic [W-1:0] last_word;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] w;
        int          gap;       // 0 none, 1 alternate, 2 random
        int          abort_at;  // <16 drop before that bit, 16 drop with last bit, else never
        int          dly;       // WAIT cycle in which the deserializer answers
        int          exp_ch;
        int          exp_kind;  // 0 word, 1 abort, 2 timeout
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference arbitration: first requester after the previous winner, wrapping.
    function automatic int rr_pick(input logic [3:0] req, input int rr);
        for (int k = 1; k <= int'(N); k++)
            if (req[(rr + k) % int'(N)]) return (rr + k) % int'(N);
        return -1;
    endfunction

    task automatic run_txn(input logic [3:0] req, input logic [15:0] w, input int gap,
                           input int abort_at, input int dly, input int exp_ch,
                           input int exp_kind);
        logic [1:0]   ch;
        logic [W-1:0] shreg;
        int           nbits, sent;
        bit           got, v, drop;
        ch    = 2'(exp_ch);
        shreg = '0;
        nbits = 0;
        sent  = 0;
        drop  = 1'b0;
        got   = 1'b0;
        req_i = req;
        data_val_i = '0;
        deser_data_val_i = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            tick();
            if (i == 0) chk("pulse_clear", 32'({word_val_o, abort_o, timeout_o}), 0);
            if (gnt_o != '0) got = 1'b1;
        end
        if (!got) begin
            chk("grant_seen", 0, 1);
            req_i = '0;
            return;
        end
        chk("gnt", 32'(gnt_o), 32'(4'(1) << ch));

        for (int k = 0; k < 300; k++) begin
            v = (gap == 0) ? 1'b1 : (gap == 1) ? (k % 2 == 0) : 1'(($urandom_range(0, 1)));
            drop = 1'b0;
            if (abort_at < int'(W) && sent == abort_at) begin drop = 1'b1; v = 1'b0; end
            if (abort_at == int'(W) && sent == int'(W) - 1) begin drop = 1'b1; v = 1'b1; end
            data_i     = 4'($urandom);
            data_val_i = 4'($urandom);
            req_i      = 4'($urandom);
            data_i[ch]     = w[4'(int'(W) - 1 - sent)];
            data_val_i[ch] = v;
            req_i[ch]      = !drop;
            #1;
            chk("fwd_val", 32'(deser_data_val_o), 32'(v));
            if (deser_data_val_o) begin
                shreg = {shreg[W-2:0], deser_data_o};
                nbits++;
            end
            tick();
            if (v) sent++;
            if (drop || sent == int'(W)) break;
        end
        req_i = '0;
        data_val_i = '0;

        if (exp_kind == 1) begin
            chk("abort", 32'(abort_o), 1);
            chk("abort_srst", 32'(deser_srst_o), 1);
            chk("abort_gnt", 32'(gnt_o), 0);
            chk("abort_noword", 32'(word_val_o), 0);
            tick();
            chk("abort_end", 32'({abort_o, deser_srst_o}), 0);
            return;
        end
        if (sent != int'(W)) chk("stream_done", 32'(sent), 32'(W));
        chk("wait_gnt", 32'(gnt_o), 0);
        chk("no_abort", 32'(abort_o), 0);
        chk("fwd_bits", 32'(nbits), 32'(W));
        chk("fwd_word", 32'(shreg), 32'(w));

        got = 1'b0;
        for (int d = 0; d < int'(TMO); d++) begin
            data_val_i       = '1;
            data_i           = 4'($urandom);
            deser_data_val_i = (d == dly);
            deser_data_i     = (d == dly) ? shreg : 16'($urandom);
            #1;
            chk("wait_val_forced", 32'(deser_data_val_o), 0);
            tick();
            deser_data_val_i = 1'b0;
            if (d == dly) begin got = 1'b1; break; end
        end
        data_val_i = '0;

        if (exp_kind == 0) begin
            chk("word_val", 32'(word_val_o), 1);
            chk("word", 32'(word_o), 32'(w));
            chk("word_ch", 32'(word_ch_o), 32'(exp_ch));
            chk("no_timeout", 32'(timeout_o), 0);
            last_word = w;
        end else begin
            chk("timeout", 32'(timeout_o), 1);
            chk("timeout_srst", 32'(deser_srst_o), 1);
            chk("timeout_noword", 32'(word_val_o), 0);
            // A late word-valid during recovery must be ignored.
            deser_data_val_i = 1'b1;
            deser_data_i     = 16'hBAD1;
            tick();
            deser_data_val_i = 1'b0;
            chk("timeout_end", 32'({timeout_o, deser_srst_o, word_val_o}), 0);
            chk("word_hold", 32'(word_o), 32'(last_word));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  r_req;
        logic [15:0] r_w;
        int r_gap, r_abort, r_dly, r_ch, r_kind, r;

        tbl[0]  = '{4'b1111, 16'h2167, 0, 99, 1, 0, 0};
        tbl[1]  = '{4'b1111, 16'hE9D3, 0, 99, 0, 1, 0};
        tbl[2]  = '{4'b1111, 16'h5A0F, 0, 99, 2, 2, 0};
        tbl[3]  = '{4'b1111, 16'hC3C3, 0, 99, 3, 3, 0};
        tbl[4]  = '{4'b1111, 16'h1234, 0, 99, 1, 0, 0};
        tbl[5]  = '{4'b0010, 16'hB7E4, 0, 99, 1, 1, 0};
        tbl[6]  = '{4'b0100, 16'hA5C3, 1, 99, 2, 2, 0};
        tbl[7]  = '{4'b0001, 16'hFFFF, 0,  7, 1, 0, 1};
        tbl[8]  = '{4'b0011, 16'h0F0F, 0, 99, 0, 1, 0};
        tbl[9]  = '{4'b1000, 16'h8001, 0, 99, 4, 3, 2};
        tbl[10] = '{4'b0100, 16'h6DB6, 0, 16, 1, 2, 0};
        tbl[11] = '{4'b1001, 16'h4C3B, 2, 99, 2, 3, 0};
        tbl[12] = '{4'b1001, 16'h0000, 0,  0, 1, 0, 1};

        arst_n_i = 1'b0;
        req_i = '0; data_i = '0; data_val_i = '0;
        deser_data_i = '0; deser_data_val_i = 1'b0;
        last_word = '0;
        model_rr = int'(N) - 1;
        #12;
        chk("rst_srst", 32'(deser_srst_o), 1);
        chk("rst_gnt", 32'(gnt_o), 0);
        chk("rst_outs", 32'({word_val_o, abort_o, timeout_o, word_o}), 0);
        @(negedge clk_i);
        arst_n_i = 1'b1;
        #1;
        chk("srst_first_cycle", 32'(deser_srst_o), 1);
        chk("gnt_after_rst", 32'(gnt_o), 0);
        tick();
        chk("srst_drop", 32'(deser_srst_o), 0);

        // Word-valid from the deserializer while idle must not produce a word.
        deser_data_val_i = 1'b1;
        deser_data_i     = 16'hDEAD;
        tick();
        tick();
        deser_data_val_i = 1'b0;
        chk("idle_ignore_val", 32'(word_val_o), 0);
        chk("idle_word_hold", 32'(word_o), 0);

        for (int i = 0; i < 13; i++) begin
            run_txn(tbl[i].req, tbl[i].w, tbl[i].gap, tbl[i].abort_at, tbl[i].dly,
                    tbl[i].exp_ch, tbl[i].exp_kind);
            model_rr = tbl[i].exp_ch;
        end

        for (int i = 0; i < 40; i++) begin
            r_req = 4'($urandom_range(1, 15));
            r_w   = 16'($urandom);
            r_gap = $urandom_range(0, 2);
            r     = $urandom_range(0, 9);
            r_abort = (r < 2) ? $urandom_range(0, 15) : (r == 2) ? 16 : 99;
            r_dly = $urandom_range(0, 5);
            r_ch  = rr_pick(r_req, model_rr);
            r_kind = (r_abort < int'(W)) ? 1 : (r_dly >= int'(TMO)) ? 2 : 0;
            run_txn(r_req, r_w, r_gap, r_abort, r_dly, r_ch, r_kind);
            model_rr = r_ch;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
